// File: rtl/store_unit_pkg.sv
// Shared access-size encoding for the store unit and its bus interface.
// Pure type definitions, no logic.
// No handshake of its own.
package store_unit_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

// File: rtl/store_unit_if.sv
// Upstream store request and data-bus write channel bundled for the store unit.
// Pure wiring, no latency.
// Backpressure is carried by st_ready and dresp_data_ok.
interface store_unit_if;
  import store_unit_pkg::*;

  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  msize_t      st_msize;
  logic        st_ready;
  logic        st_done;
  logic        st_misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [31:0] store_count;

  // The store unit itself.
  modport slave (
    input  st_valid, st_addr, st_data, st_msize, dresp_data_ok,
    output st_ready, st_done, st_misalign, dreq_valid, dreq_addr,
           dreq_size, dreq_strobe, dreq_data, store_count
  );

  // Upstream requester plus the data bus, seen from outside the unit.
  modport master (
    output st_valid, st_addr, st_data, st_msize, dresp_data_ok,
    input  st_ready, st_done, st_misalign, dreq_valid, dreq_addr,
           dreq_size, dreq_strobe, dreq_data, store_count
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: aligns a right-justified store onto 64-bit byte lanes and issues one bus write.
// Latency: bus request valid the cycle after accept; st_done the cycle after dresp_data_ok.
// Backpressure: st_ready low while a bus write is outstanding; misaligned stores are dropped.
module store_unit
  import store_unit_pkg::*;
(
  input logic        clk,
  input logic        resetn,
  store_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_addr;
  msize_t      r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  logic        r_done;
  logic        r_misalign;
  logic [31:0] r_count;

  logic        w_accept;
  logic        w_complete;
  logic        w_misalign;
  logic [2:0]  w_shift;
  logic [7:0]  w_strobe_base;
  logic [63:0] w_data_masked;
  logic [7:0]  w_strobe;
  logic [63:0] w_data;

  assign w_accept   = bus.st_valid && (r_state == IDLE);
  assign w_complete = bus.dresp_data_ok && (r_state == BUSY);

  // Decode size: alignment check, lane shift, base strobe and size-masked data.
  always_comb begin
    w_misalign    = 1'b0;
    w_shift       = 3'd0;
    w_strobe_base = 8'h00;
    w_data_masked = 64'd0;
    case (bus.st_msize)
      MSIZE1: begin
        w_shift       = bus.st_addr[2:0];
        w_strobe_base = 8'h01;
        w_data_masked = {56'd0, bus.st_data[7:0]};
      end
      MSIZE2: begin
        w_misalign    = bus.st_addr[0];
        w_shift       = {bus.st_addr[2:1], 1'b0};
        w_strobe_base = 8'h03;
        w_data_masked = {48'd0, bus.st_data[15:0]};
      end
      MSIZE4: begin
        w_misalign    = |bus.st_addr[1:0];
        w_shift       = {bus.st_addr[2], 2'b00};
        w_strobe_base = 8'h0F;
        w_data_masked = {32'd0, bus.st_data[31:0]};
      end
      default: begin
        w_misalign    = |bus.st_addr[2:0];
        w_shift       = 3'd0;
        w_strobe_base = 8'hFF;
        w_data_masked = bus.st_data;
      end
    endcase
    w_strobe = w_strobe_base << w_shift;
    w_data   = w_data_masked << {w_shift, 3'b000};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state: aligned accept opens a bus write, data_ok closes it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_misalign) w_next = BUSY;
      BUSY:    if (bus.dresp_data_ok) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-derived handshake outputs.
  always_comb begin
    bus.st_ready   = (r_state == IDLE);
    bus.dreq_valid = (r_state == BUSY);
  end

  // Request capture, completion bookkeeping and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr     <= 64'd0;
      r_size     <= MSIZE1;
      r_strobe   <= 8'h00;
      r_data     <= 64'd0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      if (w_accept) begin
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end else begin
          r_addr   <= {bus.st_addr[63:3], 3'b000};
          r_size   <= bus.st_msize;
          r_strobe <= w_strobe;
          r_data   <= w_data;
        end
      end else if (w_complete) begin
        // Lanes are cleared so the idle bus shows no stale write data.
        r_done   <= 1'b1;
        r_count  <= r_count + 32'd1;
        r_strobe <= 8'h00;
        r_data   <= 64'd0;
      end
    end
  end

  assign bus.st_done     = r_done;
  assign bus.st_misalign = r_misalign;
  assign bus.dreq_addr   = r_addr;
  assign bus.dreq_size   = r_size;
  assign bus.dreq_strobe = r_strobe;
  assign bus.dreq_data   = r_data;
  assign bus.store_count = r_count;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a scoreboard of expected bus writes.
// Inputs driven on falling edges, outputs sampled on falling edges.
// Monitor pops one expected write per bus request and checks it every BUSY cycle.
module tb_store_unit;
  import store_unit_pkg::*;

  logic clk;
  logic resetn;

  store_unit_if bus ();

  store_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bus monitor: new request pops the scoreboard, every BUSY cycle must match it.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dreq_valid === 1'b1 && !prev_valid) begin
        if (q.size() == 0) check("unexpected_req", 64'd1, 64'd0);
        else cur = q.pop_front();
      end
      if (bus.dreq_valid === 1'b1) begin
        check("dreq_addr",   bus.dreq_addr,   cur.addr);
        check("dreq_size",   64'(bus.dreq_size), 64'(cur.size));
        check("dreq_strobe", 64'(bus.dreq_strobe), 64'(cur.strobe));
        check("dreq_data",   bus.dreq_data,   cur.data);
      end
      prev_valid = (bus.dreq_valid === 1'b1);
    end
  end

  task automatic drive(input logic [63:0] a, input msize_t s, input logic [63:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_msize = s;
    bus.st_data  = d;
  endtask

  initial begin
    resetn            = 1'b0;
    bus.st_valid      = 1'b0;
    bus.st_addr       = 64'd0;
    bus.st_data       = 64'd0;
    bus.st_msize      = MSIZE1;
    bus.dresp_data_ok = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",   64'(bus.st_ready), 64'd1);
    check("rst_valid",   64'(bus.dreq_valid), 64'd0);
    check("rst_addr",    bus.dreq_addr, 64'd0);
    check("rst_size",    64'(bus.dreq_size), 64'(MSIZE1));
    check("rst_strobe",  64'(bus.dreq_strobe), 64'd0);
    check("rst_data",    bus.dreq_data, 64'd0);
    check("rst_done",    64'(bus.st_done), 64'd0);
    check("rst_mis",     64'(bus.st_misalign), 64'd0);
    check("rst_count",   64'(bus.store_count), 64'd0);
    resetn = 1'b1;

    // Byte store, data_ok two cycles into BUSY
    drive(64'h1003, MSIZE1, 64'hAB);
    q.push_back('{64'h1000, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000});
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("sb_ready_busy", 64'(bus.st_ready), 64'd0);
    check("sb_valid_busy", 64'(bus.dreq_valid), 64'd1);
    @(negedge clk);
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("sb_done",      64'(bus.st_done), 64'd1);
    check("sb_count",     64'(bus.store_count), 64'd1);
    check("sb_valid_off", 64'(bus.dreq_valid), 64'd0);
    check("sb_ready",     64'(bus.st_ready), 64'd1);
    check("idle_strobe",  64'(bus.dreq_strobe), 64'd0);
    check("idle_data",    bus.dreq_data, 64'd0);
    @(negedge clk);
    check("sb_done_pulse", 64'(bus.st_done), 64'd0);
    // data_ok in IDLE must be ignored
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("idle_ok_done",  64'(bus.st_done), 64'd0);
    check("idle_ok_count", 64'(bus.store_count), 64'd1);

    // Word store, data_ok on first BUSY cycle
    drive(64'h2004, MSIZE4, 64'hFFFF_FFFF_1234_5678);
    q.push_back('{64'h2000, MSIZE4, 8'hF0, 64'h1234_5678_0000_0000});
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("sw_done",  64'(bus.st_done), 64'd1);
    check("sw_count", 64'(bus.store_count), 64'd2);

    // Misaligned halfword is dropped
    drive(64'h3001, MSIZE2, 64'h5555);
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("sh_mis",   64'(bus.st_misalign), 64'd1);
    check("sh_valid", 64'(bus.dreq_valid), 64'd0);
    check("sh_ready", 64'(bus.st_ready), 64'd1);
    @(negedge clk);
    check("sh_mis_pulse", 64'(bus.st_misalign), 64'd0);
    check("sh_count",     64'(bus.store_count), 64'd2);

    // Back-to-back doublewords
    drive(64'h4000, MSIZE8, 64'hDEAD_BEEF_0123_4567);
    q.push_back('{64'h4000, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0123_4567});
    @(negedge clk);
    check("sd1_ready", 64'(bus.st_ready), 64'd0);
    drive(64'h4008, MSIZE8, 64'h0F1E_2D3C_4B5A_6978);
    q.push_back('{64'h4008, MSIZE8, 8'hFF, 64'h0F1E_2D3C_4B5A_6978});
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    check("sd1_done",  64'(bus.st_done), 64'd1);
    check("sd1_count", 64'(bus.store_count), 64'd3);
    check("sd_gap",    64'(bus.dreq_valid), 64'd0);
    check("sd_ready",  64'(bus.st_ready), 64'd1);
    @(negedge clk);
    // Second write in flight; a new request held high must not be taken
    bus.dresp_data_ok = 1'b0;
    drive(64'h4010, MSIZE8, 64'h7777_7777_7777_7777);
    check("sd2_ready", 64'(bus.st_ready), 64'd0);
    @(negedge clk);
    check("sd2_hold_ready", 64'(bus.st_ready), 64'd0);
    bus.st_valid = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("sd2_done",  64'(bus.st_done), 64'd1);
    check("sd2_count", 64'(bus.store_count), 64'd4);

    // Reset while BUSY with data_ok on the same edge
    drive(64'h5002, MSIZE2, 64'hBEEF);
    q.push_back('{64'h5000, MSIZE2, 8'h0C, 64'h0000_0000_BEEF_0000});
    @(negedge clk);
    bus.st_valid = 1'b0;
    resetn = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    bus.dresp_data_ok = 1'b0;
    check("rb_done",   64'(bus.st_done), 64'd0);
    check("rb_count",  64'(bus.store_count), 64'd0);
    check("rb_valid",  64'(bus.dreq_valid), 64'd0);
    check("rb_addr",   bus.dreq_addr, 64'd0);
    check("rb_strobe", 64'(bus.dreq_strobe), 64'd0);

    // Reset wins over a same-edge accept
    drive(64'h5008, MSIZE8, 64'h1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.st_valid = 1'b0;
    check("ra_valid", 64'(bus.dreq_valid), 64'd0);
    check("ra_ready", 64'(bus.st_ready), 64'd1);

    // Counter wrap from a preset value
    force dut.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_count;
    check("wrap_preset", 64'(bus.store_count), 64'hFFFF_FFFE);
    drive(64'h6005, MSIZE1, 64'h1122_33CD);
    q.push_back('{64'h6000, MSIZE1, 8'h20, 64'h0000_CD00_0000_0000});
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("wrap_max", 64'(bus.store_count), 64'hFFFF_FFFF);
    drive(64'h7000, MSIZE8, 64'hA5A5_5A5A_C3C3_3C3C);
    q.push_back('{64'h7000, MSIZE8, 8'hFF, 64'hA5A5_5A5A_C3C3_3C3C});
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    bus.dresp_data_ok = 1'b0;
    check("wrap_zero", 64'(bus.store_count), 64'd0);
    check("wrap_done", 64'(bus.st_done), 64'd1);

    @(negedge clk);
    check("sb_empty",   64'(q.size()), 64'd0);
    check("end_valid",  64'(bus.dreq_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
